// File: rtl/mem_read_axi_responder_if.sv
// AXI4 slave-side bundle for the read responder: AW/W/B write channels and AR/R read channels.
interface mem_read_axi_responder_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 256
);
   logic                      awvalid;
   logic                      awready;
   logic [ADDR_WIDTH-1:0]     awaddr;
   logic [7:0]                awlen;
   logic                      wvalid;
   logic                      wready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      wlast;
   logic                      bvalid;
   logic                      bready;
   logic                      arvalid;
   logic                      arready;
   logic [ADDR_WIDTH-1:0]     araddr;
   logic [7:0]                arlen;
   logic                      rvalid;
   logic                      rready;
   logic [DATA_WIDTH-1:0]     rdata;
   logic                      rlast;

   modport master (
      output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arlen, rready,
      input  awready, wready, bvalid, arready, rvalid, rdata, rlast
   );

   modport slave (
      input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
             arvalid, araddr, arlen, rready,
      output awready, wready, bvalid, arready, rvalid, rdata, rlast
   );
endinterface

// File: rtl/mem_read_axi_responder.sv
// AXI4 slave that answers read bursts with address^seed pattern data after a fixed latency,
// and sinks write bursts while flagging wlast mismatches.
module mem_read_axi_responder #(
   parameter int C_S_AXI_ADDR_WIDTH = 64,
   parameter int C_S_AXI_DATA_WIDTH = 256,
   parameter int C_RD_LATENCY       = 4
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   mem_read_axi_responder_if.slave   s_axi,
   input  logic [63:0]               seed,
   output logic [31:0]               rd_beat_count,
   output logic [31:0]               wr_beat_count,
   output logic                      wlast_err
);
   localparam int AW    = C_S_AXI_ADDR_WIDTH;
   localparam int NLANE = C_S_AXI_DATA_WIDTH / 64;
   localparam int BYTES = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [7:0] LAT = 8'(C_RD_LATENCY);

   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_e;
   typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

   rd_state_e                rd_state_q, rd_state_d;
   wr_state_e                wr_state_q, wr_state_d;
   logic [7:0]               lat_q, lat_d;
   logic [AW-1:0]            araddr_q, araddr_d;
   logic [7:0]               arlen_q, arlen_d;
   logic [63:0]              seed_q, seed_d;
   logic [7:0]               beat_q, beat_d;
   logic [7:0]               awlen_q, awlen_d;
   logic [7:0]               wbeat_q, wbeat_d;
   logic [31:0]              rd_cnt_q, rd_cnt_d;
   logic [31:0]              wr_cnt_q, wr_cnt_d;
   logic                     err_q, err_d;
   logic                     up_q, up_d;

   logic                     arready_c, rvalid_c, rlast_c;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_c;
   logic                     awready_c, wready_c, bvalid_c;
   logic [AW-1:0]            beat_addr, lane_addr;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rd_state_q <= RD_IDLE;
         wr_state_q <= WR_IDLE;
         lat_q      <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         seed_q     <= '0;
         beat_q     <= '0;
         awlen_q    <= '0;
         wbeat_q    <= '0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         err_q      <= 1'b0;
         up_q       <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         wr_state_q <= wr_state_d;
         lat_q      <= lat_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         seed_q     <= seed_d;
         beat_q     <= beat_d;
         awlen_q    <= awlen_d;
         wbeat_q    <= wbeat_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         err_q      <= err_d;
         up_q       <= up_d;
      end
   end

   // up_q keeps arready/awready low until the first clock edge after reset release.
   always_comb up_d = 1'b1;

   always_comb begin
      rd_state_d = rd_state_q;
      lat_d      = lat_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      seed_d     = seed_q;
      beat_d     = beat_q;
      rd_cnt_d   = rd_cnt_q;
      arready_c  = 1'b0;
      rvalid_c   = 1'b0;
      rlast_c    = 1'b0;
      rdata_c    = '0;
      beat_addr  = araddr_q + AW'(beat_q) * AW'(BYTES);
      lane_addr  = '0;
      unique case (rd_state_q)
         RD_IDLE: begin
            arready_c = up_q;
            if (s_axi.arvalid && up_q) begin
               araddr_d   = s_axi.araddr;
               arlen_d    = s_axi.arlen;
               seed_d     = seed;
               beat_d     = '0;
               lat_d      = LAT;
               rd_state_d = (C_RD_LATENCY == 0) ? RD_DATA : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (lat_q <= 8'd1) rd_state_d = RD_DATA;
            else               lat_d      = lat_q - 8'd1;
         end
         RD_DATA: begin
            rvalid_c = 1'b1;
            rlast_c  = (beat_q == arlen_q);
            for (int unsigned k = 0; k < NLANE; k++) begin
               lane_addr = beat_addr + AW'(8 * k);
               rdata_c[k*64 +: 64] = 64'(lane_addr) ^ seed_q;
            end
            if (s_axi.rready) begin
               rd_cnt_d = rd_cnt_q + 32'd1;
               beat_d   = beat_q + 8'd1;
               if (rlast_c) rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      awlen_d    = awlen_q;
      wbeat_d    = wbeat_q;
      wr_cnt_d   = wr_cnt_q;
      err_d      = err_q;
      awready_c  = 1'b0;
      wready_c   = 1'b0;
      bvalid_c   = 1'b0;
      unique case (wr_state_q)
         WR_IDLE: begin
            awready_c = up_q;
            if (s_axi.awvalid && up_q) begin
               awlen_d    = s_axi.awlen;
               wbeat_d    = '0;
               wr_state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            wready_c = 1'b1;
            if (s_axi.wvalid) begin
               wr_cnt_d = wr_cnt_q + 32'd1;
               if (s_axi.wlast != (wbeat_q == awlen_q)) err_d = 1'b1;
               // Burst length comes from awlen alone; wlast only feeds the error flag.
               if (wbeat_q == awlen_q) wr_state_d = WR_RESP;
               else                    wbeat_d    = wbeat_q + 8'd1;
            end
         end
         WR_RESP: begin
            bvalid_c = 1'b1;
            if (s_axi.bready) wr_state_d = WR_IDLE;
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   assign s_axi.arready = arready_c;
   assign s_axi.rvalid  = rvalid_c;
   assign s_axi.rlast   = rlast_c;
   assign s_axi.rdata   = rdata_c;
   assign s_axi.awready = awready_c;
   assign s_axi.wready  = wready_c;
   assign s_axi.bvalid  = bvalid_c;
   assign rd_beat_count = rd_cnt_q;
   assign wr_beat_count = wr_cnt_q;
   assign wlast_err     = err_q;
endmodule

// File: tb/tb_mem_read_axi_responder.sv
// Directed and randomized bench for mem_read_axi_responder against an arithmetic reference model.
module tb_mem_read_axi_responder;
   localparam int AW  = 64;
   localparam int DW  = 256;
   localparam int LAT = 4;
   localparam int NL  = DW / 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [63:0]   seed;
   logic [31:0]   rd_cnt, wr_cnt;
   logic          werr;

   always #5 clk = ~clk;

   mem_read_axi_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

   mem_read_axi_responder #(
      .C_S_AXI_ADDR_WIDTH(AW),
      .C_S_AXI_DATA_WIDTH(DW),
      .C_RD_LATENCY(LAT)
   ) dut (
      .ap_clk(clk),
      .ap_rst_n(rst_n),
      .s_axi(axi),
      .seed(seed),
      .rd_beat_count(rd_cnt),
      .wr_beat_count(wr_cnt),
      .wlast_err(werr)
   );

   int            n_assert = 0;
   int            n_fail = 0;
   int unsigned   m_rd = 0;
   int unsigned   m_wr = 0;
   logic          m_err = 1'b0;
   logic [DW-1:0] got [0:255];
   int            last_lat;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: each 64-bit lane is its own byte address XOR the seed, in 64-bit wrapping arithmetic.
   function automatic logic [DW-1:0] exp_rdata(input logic [63:0] a, input int beat, input logic [63:0] s);
      logic [DW-1:0] r;
      for (int k = 0; k < NL; k++)
         r[k*64 +: 64] = (a + 64'(beat) * 64'(DW/8) + 64'(8*k)) ^ s;
      return r;
   endfunction

   task automatic idle_inputs;
      axi.awvalid = 1'b0; axi.awaddr = '0; axi.awlen = '0;
      axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
      axi.bready = 1'b0;
      axi.arvalid = 1'b0; axi.araddr = '0; axi.arlen = '0;
      axi.rready = 1'b0;
      seed = '0;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      idle_inputs();
      m_rd = 0; m_wr = 0; m_err = 1'b0;
      repeat (3) tick();
      chk("rst_arready", axi.arready, 0);
      chk("rst_rvalid", axi.rvalid, 0);
      chk("rst_rdata", axi.rdata, 0);
      chk("rst_counts", {rd_cnt, wr_cnt, werr}, 0);
      rst_n = 1'b1;
      #1;
      chk("pre_edge_arready", axi.arready, 0);
      tick();
      chk("post_edge_ready", {axi.arready, axi.awready, axi.wready}, 3'b110);
   endtask

   // mode 0: rready always high, 1: random, 2: 1-0-1 pattern
   task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [63:0] sd, input int mode);
      int beat = 0;
      int cyc = 0;
      int wait_n = 1;
      logic [DW-1:0] cur;
      chk("ar_idle_arready", axi.arready, 1);
      axi.arvalid = 1'b1; axi.araddr = addr; axi.arlen = len; seed = sd;
      tick();
      axi.arvalid = 1'b0; axi.araddr = {$urandom, $urandom}; axi.arlen = 8'($urandom);
      seed = {$urandom, $urandom};
      while (!axi.rvalid && wait_n < 300) begin
         tick();
         wait_n++;
      end
      last_lat = wait_n;
      chk("rd_latency", wait_n, LAT + 1);
      chk("rd_arready_busy", axi.arready, 0);
      while (beat <= int'(len) && cyc < 2000) begin
         chk("rd_rvalid", axi.rvalid, 1);
         chk("rd_rdata", axi.rdata, exp_rdata(addr, beat, sd));
         chk("rd_rlast", axi.rlast, beat == int'(len));
         cur = axi.rdata;
         case (mode)
            0:       axi.rready = 1'b1;
            1:       axi.rready = 1'($urandom_range(0, 1));
            default: axi.rready = (cyc % 3 != 1);
         endcase
         tick();
         cyc++;
         if (axi.rready) begin
            got[beat] = cur;
            beat++;
            m_rd++;
         end
      end
      axi.rready = 1'b0;
      chk("rd_done_beats", beat, int'(len) + 1);
      chk("rd_idle_arready", axi.arready, 1);
      chk("rd_idle_rvalid", axi.rvalid, 0);
      chk("rd_beat_count", rd_cnt, m_rd);
   endtask

   // bad_beat < 0: correct wlast; otherwise wlast asserted only on that beat
   task automatic do_write(input logic [7:0] len, input int bad_beat, input int gaps, input int bdly);
      logic last;
      chk("aw_idle", {axi.awready, axi.wready}, 2'b10);
      axi.awvalid = 1'b1; axi.awlen = len; axi.awaddr = {$urandom, $urandom};
      tick();
      axi.awvalid = 1'b0; axi.awlen = 8'($urandom);
      for (int beat = 0; beat <= int'(len); beat++) begin
         if (gaps != 0) begin
            repeat ($urandom_range(0, 2)) begin
               axi.wvalid = 1'b0;
               tick();
            end
         end
         chk("w_wready", axi.wready, 1);
         chk("w_bvalid_early", axi.bvalid, 0);
         last = (beat == int'(len));
         axi.wvalid = 1'b1;
         axi.wdata  = {8{$urandom}};
         axi.wstrb  = '1;
         axi.wlast  = (bad_beat < 0) ? last : (beat == bad_beat);
         tick();
         m_wr++;
         if (axi.wlast != last) m_err = 1'b1;
         chk("w_err", werr, m_err);
      end
      axi.wvalid = 1'b0; axi.wlast = 1'b0;
      chk("b_bvalid", axi.bvalid, 1);
      chk("b_wready", axi.wready, 0);
      repeat (bdly) begin
         tick();
         chk("b_hold", axi.bvalid, 1);
      end
      axi.bready = 1'b1;
      tick();
      axi.bready = 1'b0;
      chk("b_done", {axi.bvalid, axi.awready}, 2'b01);
      chk("wr_beat_count", wr_cnt, m_wr);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int wait_n;
      logic [63:0] a;
      do_reset();

      do_read(64'h1000, 8'd3, 64'h0, 0);
      chk("r040_lat", last_lat, 5);
      chk("r040_b0l0", got[0][63:0], 64'h1000);
      chk("r040_b0l3", got[0][255:192], 64'h1018);
      chk("r040_b3l0", got[3][63:0], 64'h1060);
      chk("r040_cnt", rd_cnt, 4);

      do_read(64'hFFFF_FFFF_FFFF_FFE0, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      chk("r041_b0l0", got[0][63:0], 64'h1F);
      chk("r041_b1l0", got[1][63:0], 64'hFFFF_FFFF_FFFF_FFFF);

      do_read(64'h2340, 8'd7, 64'hA5A5_0000_1234_5678, 2);

      do_reset();
      fork
         do_read(64'h8000_0000, 8'd15, 64'h0123_4567_89AB_CDEF, 0);
         do_write(8'd15, -1, 0, 0);
      join
      chk("r044_rd_cnt", rd_cnt, 16);
      chk("r044_wr_cnt", wr_cnt, 16);
      chk("r044_werr", werr, 0);

      do_reset();
      do_write(8'd3, 2, 0, 3);
      chk("r043_werr", werr, 1);
      chk("r043_wr_cnt", wr_cnt, 4);

      do_reset();
      for (int i = 0; i < 12; i++) begin
         a = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a = {32'hFFFF_FFFF, 32'hFFFF_FF00 | 32'($urandom_range(0, 255))};
         do_read(a, 8'($urandom_range(0, 15)), {$urandom, $urandom}, $urandom_range(0, 2));
      end
      for (int i = 0; i < 6; i++) begin
         fork
            do_read({$urandom, $urandom}, 8'($urandom_range(0, 7)), {$urandom, $urandom}, 1);
            do_write(8'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1,
                     1, $urandom_range(0, 3));
         join
      end

      axi.arvalid = 1'b1; axi.araddr = 64'h4000; axi.arlen = 8'd7; seed = 64'h55;
      tick();
      axi.arvalid = 1'b0;
      axi.rready = 1'b1;
      wait_n = 0;
      while (!axi.rvalid && wait_n < 300) begin
         tick();
         wait_n++;
      end
      chk("r045_rvalid_seen", axi.rvalid, 1);
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("r045_rst_r", {axi.arready, axi.rvalid, axi.rlast}, 0);
      chk("r045_rst_rdata", axi.rdata, 0);
      chk("r045_rst_w", {axi.awready, axi.wready, axi.bvalid, werr}, 0);
      chk("r045_rst_cnt", {rd_cnt, wr_cnt}, 0);
      idle_inputs();
      axi.rready = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("r045_arready", axi.arready, 1);
      for (int i = 0; i < 10; i++) begin
         chk("r045_no_stale", {axi.rvalid, axi.bvalid}, 0);
         tick();
      end
      chk("r045_rd_cnt", rd_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
